// File: rtl/cpt_ctrl8.sv
// cpt_ctrl8: sequencing controller for an 8-bit counter with a
// programmable period, one-shot/periodic reload and activate gating.
module cpt_ctrl8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       activate,
   input  logic       cfg_we,
   input  logic [7:0] cfg_period,
   input  logic       cfg_reload,
   input  logic       start,
   input  logic       stop,
   output logic [7:0] out,
   output logic       busy,
   output logic       tc,
   output logic       done,
   output logic       cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] per_q, per_d;
   logic       rel_q, rel_d;
   logic       tc_q, tc_d;
   logic       err_q, err_d;
   logic [7:0] last_v;
   logic       term_v;

   // P=0 wraps to a compare against 255, i.e. a 256-count period
   assign last_v = per_q - 8'd1;
   assign term_v = (cnt_q == last_v);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         per_q   <= 8'd0;
         rel_q   <= 1'b0;
         tc_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         rel_q   <= rel_d;
         tc_q    <= tc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      rel_d   = rel_q;
      tc_d    = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (cfg_we) begin
               per_d = cfg_period;
               rel_d = cfg_reload;
            end
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cfg_we) begin
               err_d = 1'b1;
            end
            if (stop) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else if (start) begin
               cnt_d = 8'd0;
            end else if (activate) begin
               if (term_v) begin
                  cnt_d   = 8'd0;
                  tc_d    = 1'b1;
                  state_d = rel_q ? S_RUN : S_DONE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_DONE: begin
            cnt_d = 8'd0;
            if (cfg_we) begin
               per_d = cfg_period;
               rel_d = cfg_reload;
            end
            if (stop) begin
               state_d = S_IDLE;
            end else if (start) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign out     = cnt_q;
   assign busy    = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign tc      = tc_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_cpt_ctrl8.sv
// Bench for cpt_ctrl8: directed scenarios plus random traffic, all
// outputs compared each cycle against a counting model.
module tb_cpt_ctrl8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       activate = 1'b0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_period = 8'd0;
   logic       cfg_reload = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] out;
   logic       busy, tc, done, cfg_err;

   int checks = 0;
   int errors = 0;

   // model: period as 1..256, count as plain integer
   int m_per = 256;
   bit m_rel = 0;
   bit m_run = 0;
   bit m_done = 0;
   int m_cnt = 0;
   bit m_tc = 0;
   bit m_err = 0;
   int tc_edges[$];
   int edge_no = 0;

   cpt_ctrl8 dut (
      .clk(clk), .reset(reset), .activate(activate),
      .cfg_we(cfg_we), .cfg_period(cfg_period),
      .cfg_reload(cfg_reload), .start(start), .stop(stop),
      .out(out), .busy(busy), .tc(tc), .done(done),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_per = 256; m_rel = 0; m_run = 0; m_done = 0;
      m_cnt = 0; m_tc = 0; m_err = 0;
   endtask

   task automatic model_step(bit st, bit sp, bit act, bit we,
                             int p, bit r);
      m_tc = 0;
      m_err = 0;
      if (we) begin
         if (m_run) m_err = 1;
         else begin
            m_per = (p == 0) ? 256 : p;
            m_rel = r;
         end
      end
      if (m_run) begin
         if (sp) begin m_run = 0; m_cnt = 0; end
         else if (st) m_cnt = 0;
         else if (act) begin
            if (m_cnt + 1 == m_per) begin
               m_cnt = 0;
               m_tc = 1;
               if (!m_rel) begin m_run = 0; m_done = 1; end
            end else m_cnt++;
         end
      end else if (m_done) begin
         if (sp) m_done = 0;
         else if (st) begin m_done = 0; m_run = 1; m_cnt = 0; end
      end else if (st) begin
         m_run = 1; m_cnt = 0;
      end
   endtask

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("out", int'(out), m_cnt);
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("tc", int'(tc), int'(m_tc));
      chk("cfg_err", int'(cfg_err), int'(m_err));
   endtask

   task automatic tick(bit st, bit sp, bit act, bit we, int p, bit r);
      start = st; stop = sp; activate = act;
      cfg_we = we; cfg_period = 8'(p); cfg_reload = r;
      @(posedge clk);
      edge_no++;
      model_step(st, sp, act, we, p, r);
      if (m_tc) tc_edges.push_back(edge_no);
      #1;
      chk_all();
      start = 0; stop = 0; cfg_we = 0;
   endtask

   task automatic run(int n, bit act);
      for (int i = 0; i < n; i++) tick(0, 0, act, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1;
      #1;
      model_reset();
      chk_all();
      @(posedge clk);
      #1;
      reset = 0;
      chk_all();
   endtask

   initial begin
      int s;
      #1;
      model_reset();
      chk_all();
      @(posedge clk);
      #1;
      reset = 0;

      // one-shot P=5
      tick(0, 0, 0, 1, 5, 0);
      tick(1, 0, 1, 0, 0, 0);
      s = edge_no;
      tc_edges.delete();
      run(15, 1);
      chk("oneshot_tc_cnt", tc_edges.size(), 1);
      if (tc_edges.size() > 0) chk("oneshot_tc_at", tc_edges[0] - s, 5);

      // periodic P=4 with gating 1,0,1,1,...
      tick(0, 0, 0, 1, 4, 1);
      tick(1, 0, 1, 0, 0, 0);
      s = edge_no;
      tc_edges.delete();
      tick(0, 0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      run(11, 1);
      chk("gate_tc_cnt", tc_edges.size(), 3);
      if (tc_edges.size() == 3) begin
         chk("gate_tc0", tc_edges[0] - s, 5);
         chk("gate_tc1", tc_edges[1] - tc_edges[0], 4);
         chk("gate_tc2", tc_edges[2] - tc_edges[1], 4);
      end
      tick(0, 1, 0, 0, 0, 0);

      // P=0 periodic wrap
      tick(0, 0, 0, 1, 0, 1);
      tick(1, 0, 1, 0, 0, 0);
      s = edge_no;
      tc_edges.delete();
      run(515, 1);
      chk("wrap_tc_cnt", tc_edges.size(), 2);
      if (tc_edges.size() == 2) begin
         chk("wrap_tc0", tc_edges[0] - s, 256);
         chk("wrap_tc1", tc_edges[1] - s, 512);
      end
      tick(0, 1, 0, 0, 0, 0);

      // priority: stop / start versus terminal at out=2, P=3
      tick(0, 0, 0, 1, 3, 1);
      tick(1, 0, 1, 0, 0, 0);
      run(2, 1);
      chk("prio_pre", int'(out), 2);
      tick(0, 1, 1, 0, 0, 0);
      tick(1, 0, 1, 0, 0, 0);
      run(2, 1);
      tick(1, 0, 1, 0, 0, 0);
      chk("prio_restart_busy", int'(busy), 1);
      tick(0, 1, 0, 0, 0, 0);

      // config lockout in RUN, then reconfigure in DONE
      tick(0, 0, 0, 1, 3, 0);
      tick(1, 0, 1, 0, 0, 0);
      s = edge_no;
      tc_edges.delete();
      tick(0, 0, 1, 1, 9, 0);
      run(4, 1);
      if (tc_edges.size() > 0) chk("lock_tc_at", tc_edges[0] - s, 3);
      else chk("lock_tc_cnt", 0, 1);
      tick(0, 0, 0, 1, 9, 0);
      tick(1, 0, 1, 0, 0, 0);
      s = edge_no;
      tc_edges.delete();
      run(10, 1);
      if (tc_edges.size() > 0) chk("done_cfg_tc_at", tc_edges[0] - s, 9);
      else chk("done_cfg_tc_cnt", 0, 1);

      // async reset mid-run at out=7
      tick(0, 0, 0, 1, 20, 1);
      tick(1, 0, 1, 0, 0, 0);
      run(7, 1);
      chk("pre_reset_out", int'(out), 7);
      #2;
      do_reset();
      tick(1, 0, 1, 0, 0, 0);
      s = edge_no;
      tc_edges.delete();
      run(258, 1);
      if (tc_edges.size() > 0) chk("post_reset_tc_at", tc_edges[0] - s, 256);
      else chk("post_reset_tc_cnt", 0, 1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         bit st, sp, act, we, r;
         int p;
         st  = ($urandom_range(0, 29) == 0);
         sp  = ($urandom_range(0, 59) == 0);
         act = ($urandom_range(0, 3) != 0);
         we  = ($urandom_range(0, 9) == 0);
         p   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
         r   = $urandom_range(0, 1);
         tick(st, sp, act, we, p, r);
         if (i == 2000) begin
            #2;
            do_reset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpt_ctrl8.md
# cpt_ctrl8

Sequencing controller for the 8-bit binary counter datapath. It holds a programmable period and a reload mode, starts and stops counting on request, and gates counting with `activate`. It flags terminal count, and either auto-reloads (periodic) or parks in DONE (one-shot). It is the synchronous, software-controllable front end for counter instances that need a defined period instead of free-running ripple behaviour.

## Interface
- No parameters; the width is fixed at 8 bits.
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately
- `activate`  in  1  count enable; the counter advances only on cycles where this is 1 and the state is RUN
- `cfg_we`  in  1  configuration write strobe
- `cfg_period`  in  8  period P sampled on `cfg_we`; P=0 means 256
- `cfg_reload`  in  1  mode sampled on `cfg_we`; 1 = periodic, 0 = one-shot
- `start`  in  1  single-cycle start/restart request
- `stop`  in  1  single-cycle abort request
- `out`  out  8  current count value
- `busy`  out  1  1 while state is RUN
- `tc`  out  1  one-cycle terminal-count pulse
- `done`  out  1  1 while state is DONE
- `cfg_err`  out  1  one-cycle pulse when `cfg_we` is rejected

## Operation
- Registers:
  - period P, reset 0 (256 counts)
  - mode R, reset 0
  - state, reset IDLE
  - `out`, reset 0
- On `reset`: all outputs are 0.
- States: IDLE, RUN, DONE. `busy` = (state==RUN). `done` = (state==DONE). Both are decoded from registered state.
- Configuration:
  - `cfg_we` in IDLE or DONE loads P and R at the edge.
  - `cfg_we` in RUN is ignored; P and R are unchanged and `cfg_err` pulses high for the next cycle.
- IDLE:
  - `out` holds 0.
  - `start` → RUN, `out`<=0.
- RUN, per edge, in priority order:
  1. `stop` → IDLE, `out`<=0, no `tc`.
  2. `start` → restart: stays RUN, `out`<=0, no `tc`.
  3. `activate`=1 and `out`==(P−1) mod 256 → terminal event: `out`<=0 and `tc`<=1. Next state is RUN if R=1, else DONE.
  4. `activate`=1 otherwise → `out`<=`out`+1.
  5. `activate`=0 → all held.
- DONE:
  - `out` holds 0.
  - `start` → RUN, `out`<=0.
  - `stop` → IDLE.
  - If both are asserted, `stop` wins.
- `start` and `cfg_we` in the same cycle in IDLE/DONE: the run uses the newly written P/R.
- `stop` in IDLE is a no-op.
- Arithmetic is modulo 256. With P=0 the terminal compare is against 255, so a full cycle is 256 counts.
- `activate` is a synchronous input and has no effect outside RUN.

## Timing
- `start` sampled at edge k: `busy`=1 and `out`=0 after edge k.
- With `activate` held at 1, `out`=n after edge k+n, for n<P.
- Terminal event at edge k+P: after it, `out`=0 and `tc`=1 for exactly one cycle.
  - If R=0, `done`=1 and `busy`=0 from that same edge.
  - If R=1, the next `tc` follows P edges later.
- `tc` period in periodic mode with continuous `activate`: exactly P cycles (256 for P=0).
- Each `activate`=0 cycle in RUN stretches the period by one cycle. `tc` never asserts on a cycle where `activate` was 0.
- `cfg_err` asserts on the cycle after the rejected `cfg_we` and lasts one cycle.
- Reset asserted mid-run: outputs go to reset values asynchronously, with no `tc` and no `done`.
- After reset deasserts, the first active edge is ordinary and the state is IDLE.

## Test plan
- One-shot: reset, `cfg_we` with P=5, R=0, then `start`, `activate`=1.
  - Required: `out` 0,1,2,3,4, then 0 with a single `tc` pulse 5 edges after start.
  - `done`=1 and `busy`=0 afterwards; `out` stays 0 for 10 more cycles.
- Periodic with gating: P=4, R=1, `activate` toggled 1,0,1,1,1,…
  - Required: the first `tc` comes 5 edges after start, then one every 4 edges.
  - `out` holds its value on `activate`=0 cycles.
- P=0 wrap: P=0, R=1, `activate`=1.
  - Required: `out` reaches 255, then 0 with `tc` 256 edges after start; the second `tc` is at 512.
- Priority: P=3; `stop` and the terminal condition (`out`=2) in the same cycle.
  - Required: IDLE, `out`=0, no `tc`.
  - Repeat with `start` in place of `stop`: stays RUN, `out`=0, no `tc`.
- Config lockout: `cfg_we` with P=9 during RUN with P=3.
  - Required: `cfg_err` pulses one cycle; the period stays 3, so `tc` comes 3 edges after start.
  - `cfg_we` with P=9 in DONE, then `start`: next `tc` comes 9 edges after start.
- Async reset: assert `reset` between edges while RUN with `out`=7.
  - Required: before the next edge, `out`=0, `busy`=0, `done`=0, `tc`=0, `cfg_err`=0.
  - After release, `start` with the default P=0 gives `tc` 256 edges after start.
